// File: rtl/tcdm_bank_rr_arb.sv
// tcdm_bank_rr_arb: per-bank round-robin arbiter of the TCDM crossbar.
// Collects the decoded requests of NumIn masters aimed at one bank and picks
// one winner per cycle, starting at a rotating (or externally supplied)
// priority index. The winner's payload goes to the bank, and the bank grant
// goes back to the winner only. A saturating counter tracks conflict cycles.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   flush_i          synchronous clear of the round-robin pointer
//   rr_i             external priority start index (used when ExtPrio != 0)
//   req_i / gnt_o    per-master request in / grant out (gnt_o one-hot or zero)
//   data_i           per-master request payloads
//   req_o / gnt_i    request to bank / grant from bank
//   data_o, idx_o    payload and index of the current winner
//   cnt_clr_i        synchronous clear of the conflict counter
//   conflict_cnt_o   number of cycles with two or more requests (saturating)
module tcdm_bank_rr_arb #(
    parameter int unsigned NumIn     = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ExtPrio   = 0,
    parameter int unsigned CntWidth  = 16,
    localparam int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic [IdxWidth-1:0]                  rr_i,
    input  logic [NumIn-1:0]                     req_i,
    output logic [NumIn-1:0]                     gnt_o,
    input  logic [NumIn-1:0][DataWidth-1:0]      data_i,
    output logic                                 req_o,
    input  logic                                 gnt_i,
    output logic [DataWidth-1:0]                 data_o,
    output logic [IdxWidth-1:0]                  idx_o,
    input  logic                                 cnt_clr_i,
    output logic [CntWidth-1:0]                  conflict_cnt_o
);

    if (NumIn == 1) begin : gen_single
        // Single master: plain passthrough, nothing to arbitrate or count.
        logic unused_in;

        assign req_o          = req_i[0];
        assign gnt_o          = gnt_i;
        assign idx_o          = '0;
        assign data_o         = data_i[0];
        assign conflict_cnt_o = '0;
        assign unused_in      = ^{clk_i, rst_ni, flush_i, rr_i, cnt_clr_i};

    end else begin : gen_arb
        logic [IdxWidth-1:0] rr_q;
        logic [IdxWidth-1:0] prio;
        logic [IdxWidth-1:0] win_idx;
        logic                handshake;
        logic                conflict;
        logic [CntWidth-1:0] cnt_q;

        assign req_o     = |req_i;
        assign handshake = req_o & gnt_i;

        // At least two bits set: clearing the lowest set bit leaves something.
        assign conflict  = |(req_i & (req_i - NumIn'(1)));

        // Priority start index; out-of-range external values fall back to 0.
        always_comb begin
            prio = rr_q;
            if (ExtPrio != 0) begin
                prio = (32'(rr_i) < NumIn) ? rr_i : '0;
            end
        end

        // Scan prio, prio+1, ..., wrapping at NumIn; first requester wins.
        always_comb begin
            logic        found;
            logic [31:0] cand;
            found   = 1'b0;
            cand    = '0;
            win_idx = '0;
            for (int unsigned i = 0; i < NumIn; i++) begin
                cand = 32'(prio) + i;
                if (cand >= NumIn) begin
                    cand = cand - NumIn;
                end
                if (!found && req_i[cand[IdxWidth-1:0]]) begin
                    found   = 1'b1;
                    win_idx = cand[IdxWidth-1:0];
                end
            end
        end

        assign idx_o  = win_idx;
        assign data_o = data_i[win_idx];

        // Grant returned only to the winner, and only on a bank handshake.
        always_comb begin
            gnt_o = '0;
            for (int unsigned i = 0; i < NumIn; i++) begin
                gnt_o[i] = handshake && (win_idx == IdxWidth'(i));
            end
        end

        // Round-robin pointer: moves past the winner after each handshake.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_q <= '0;
            end else if (ExtPrio == 0) begin
                if (flush_i) begin
                    rr_q <= '0;
                end else if (handshake) begin
                    rr_q <= (32'(win_idx) == NumIn - 1) ? '0 : win_idx + IdxWidth'(1);
                end
            end
        end

        // Saturating conflict counter; clear has priority over increment.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (cnt_clr_i) begin
                cnt_q <= '0;
            end else if (conflict && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end

        assign conflict_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_tcdm_bank_rr_arb.sv
// Directed bench for tcdm_bank_rr_arb: four instances (4-way RR with narrow
// counter, 3-way RR, 5-way external priority, single master).
module tb_tcdm_bank_rr_arb;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NumIn=4, internal RR, 4-bit counter
    logic              a_flush, a_req_o, a_gnt_i, a_clr;
    logic [1:0]        a_rr, a_idx;
    logic [3:0]        a_req, a_gnt_o, a_cnt;
    logic [3:0][31:0]  a_data;
    logic [31:0]       a_data_o;

    tcdm_bank_rr_arb #(.NumIn(4), .DataWidth(32), .ExtPrio(0), .CntWidth(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .rr_i(a_rr),
        .req_i(a_req), .gnt_o(a_gnt_o), .data_i(a_data), .req_o(a_req_o),
        .gnt_i(a_gnt_i), .data_o(a_data_o), .idx_o(a_idx),
        .cnt_clr_i(a_clr), .conflict_cnt_o(a_cnt)
    );

    // Instance B: NumIn=3, internal RR
    logic              b_flush, b_req_o, b_gnt_i, b_clr;
    logic [1:0]        b_rr, b_idx;
    logic [2:0]        b_req, b_gnt_o;
    logic [2:0][31:0]  b_data;
    logic [31:0]       b_data_o;
    logic [15:0]       b_cnt;

    tcdm_bank_rr_arb #(.NumIn(3), .DataWidth(32), .ExtPrio(0), .CntWidth(16)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .rr_i(b_rr),
        .req_i(b_req), .gnt_o(b_gnt_o), .data_i(b_data), .req_o(b_req_o),
        .gnt_i(b_gnt_i), .data_o(b_data_o), .idx_o(b_idx),
        .cnt_clr_i(b_clr), .conflict_cnt_o(b_cnt)
    );

    // Instance C: NumIn=5, external priority
    logic              c_flush, c_req_o, c_gnt_i, c_clr;
    logic [2:0]        c_rr, c_idx;
    logic [4:0]        c_req, c_gnt_o;
    logic [4:0][31:0]  c_data;
    logic [31:0]       c_data_o;
    logic [15:0]       c_cnt;

    tcdm_bank_rr_arb #(.NumIn(5), .DataWidth(32), .ExtPrio(1), .CntWidth(16)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .rr_i(c_rr),
        .req_i(c_req), .gnt_o(c_gnt_o), .data_i(c_data), .req_o(c_req_o),
        .gnt_i(c_gnt_i), .data_o(c_data_o), .idx_o(c_idx),
        .cnt_clr_i(c_clr), .conflict_cnt_o(c_cnt)
    );

    // Instance D: single master passthrough
    logic              d_flush, d_req_o, d_gnt_i, d_clr;
    logic [0:0]        d_rr, d_idx, d_req, d_gnt_o;
    logic [0:0][31:0]  d_data;
    logic [31:0]       d_data_o;
    logic [15:0]       d_cnt;

    tcdm_bank_rr_arb #(.NumIn(1), .DataWidth(32), .ExtPrio(0), .CntWidth(16)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(d_flush), .rr_i(d_rr),
        .req_i(d_req), .gnt_o(d_gnt_o), .data_i(d_data), .req_o(d_req_o),
        .gnt_i(d_gnt_i), .data_o(d_data_o), .idx_o(d_idx),
        .cnt_clr_i(d_clr), .conflict_cnt_o(d_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        a_flush = 0; a_rr = '0; a_req = '0; a_gnt_i = 0; a_clr = 0;
        b_flush = 0; b_rr = '0; b_req = '0; b_gnt_i = 0; b_clr = 0;
        c_flush = 0; c_rr = '0; c_req = '0; c_gnt_i = 0; c_clr = 0;
        d_flush = 0; d_rr = '0; d_req = '0; d_gnt_i = 0; d_clr = 0;
        for (int k = 0; k < 4; k++) a_data[k] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 3; k++) b_data[k] = 32'hB000_0000 + 32'(k);
        for (int k = 0; k < 5; k++) c_data[k] = 32'hC000_0000 + 32'(k);
        d_data[0] = 32'hD000_0000;

        // Reset values
        #12 rst_n = 1'b1;
        #1;
        chk("rst_req_o", 32'(a_req_o), 32'd0);
        chk("rst_gnt_o", 32'(a_gnt_o), 32'd0);
        chk("rst_idx",   32'(a_idx),   32'd0);
        chk("rst_cnt",   32'(a_cnt),   32'd0);
        chk("rst_data",  a_data_o,     32'hA000_0000);

        // All four requesting with grant: winner rotates 0,1,2,3
        for (int k = 0; k < 4; k++) begin
            step();
            a_req = 4'b1111; a_gnt_i = 1'b1;
            #1;
            chk("rot_idx",  32'(a_idx),   32'(k));
            chk("rot_gnt",  32'(a_gnt_o), 32'(1) << k);
            chk("rot_data", a_data_o,     32'hA000_0000 + 32'(k));
        end

        // Held requests without bank grant: winner stays, no grant
        for (int k = 0; k < 3; k++) begin
            step();
            a_req = 4'b1010; a_gnt_i = 1'b0;
            #1;
            if (k == 0) chk("cnt_after_rot", 32'(a_cnt), 32'd4);
            chk("wait_idx", 32'(a_idx),   32'd1);
            chk("wait_gnt", 32'(a_gnt_o), 32'd0);
        end
        step();
        a_gnt_i = 1'b1;
        #1;
        chk("hs_idx", 32'(a_idx),   32'd1);
        chk("hs_gnt", 32'(a_gnt_o), 32'b0010);
        step();
        a_req = 4'b0110; a_gnt_i = 1'b0;
        #1;
        chk("ptr2_idx", 32'(a_idx), 32'd2);

        // Pointer wrap from 3 back to 0
        step();
        a_req = 4'b0100; a_gnt_i = 1'b1;
        #1;
        chk("to3_idx", 32'(a_idx), 32'd2);
        step();
        a_req = 4'b1000; a_gnt_i = 1'b1;
        #1;
        chk("at3_idx", 32'(a_idx),   32'd3);
        chk("at3_gnt", 32'(a_gnt_o), 32'b1000);
        step();
        a_req = 4'b1001; a_gnt_i = 1'b0;
        #1;
        chk("wrap_idx", 32'(a_idx), 32'd0);

        // No requests: defaults even with bank grant high
        step();
        a_req = 4'b0000; a_gnt_i = 1'b1;
        #1;
        chk("idle_req_o", 32'(a_req_o), 32'd0);
        chk("idle_gnt",   32'(a_gnt_o), 32'd0);
        chk("idle_idx",   32'(a_idx),   32'd0);
        chk("idle_data",  a_data_o,     32'hA000_0000);

        // Conflict counter: clear, saturate at 15, clear over increment
        step();
        a_req = 4'b0011; a_gnt_i = 1'b0; a_clr = 1'b1;
        #1;
        step();
        a_clr = 1'b0;
        #1;
        chk("cnt_clr", 32'(a_cnt), 32'd0);
        exp_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            chk("cnt_run", 32'(a_cnt), 32'(exp_cnt));
        end
        a_req = 4'b0001;
        step();
        chk("cnt_single", 32'(a_cnt), 32'd15);
        a_req = 4'b0011; a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        #1;
        chk("cnt_clr_win", 32'(a_cnt), 32'd0);
        step();
        chk("cnt_restart", 32'(a_cnt), 32'd1);
        a_req = 4'b0000;

        // Three masters: non-power-of-two wrap and flush priority
        step();
        b_req = 3'b100; b_gnt_i = 1'b1;
        #1;
        chk("b_idx2", 32'(b_idx),   32'd2);
        chk("b_gnt2", 32'(b_gnt_o), 32'b100);
        chk("b_data2", b_data_o,    32'hB000_0002);
        step();
        b_req = 3'b011; b_gnt_i = 1'b0;
        #1;
        chk("b_wrap", 32'(b_idx), 32'd0);
        step();
        b_flush = 1'b1; b_req = 3'b001; b_gnt_i = 1'b1;
        #1;
        chk("b_fl_idx", 32'(b_idx),   32'd0);
        chk("b_fl_gnt", 32'(b_gnt_o), 32'b001);
        step();
        b_flush = 1'b0; b_req = 3'b011; b_gnt_i = 1'b0;
        #1;
        chk("b_flush_wins", 32'(b_idx), 32'd0);
        step();
        b_req = 3'b010; b_gnt_i = 1'b1;
        #1;
        chk("b_idx1", 32'(b_idx), 32'd1);
        step();
        b_req = 3'b000; b_gnt_i = 1'b0; b_flush = 1'b1;
        #1;
        step();
        b_flush = 1'b0; b_req = 3'b110;
        #1;
        chk("b_flush_only", 32'(b_idx), 32'd1);
        b_req = 3'b000;

        // External priority, including out-of-range rr_i
        c_flush = 1'b1;
        step();
        c_rr = 3'd2; c_req = 5'b00011; c_gnt_i = 1'b1;
        #1;
        chk("c_rr2", 32'(c_idx), 32'd0);
        chk("c_gnt", 32'(c_gnt_o), 32'b00001);
        step();
        c_rr = 3'd6; c_req = 5'b00011;
        #1;
        chk("c_rr6", 32'(c_idx), 32'd0);
        step();
        c_rr = 3'd7; c_req = 5'b00110; c_gnt_i = 1'b0;
        #1;
        chk("c_rr7", 32'(c_idx), 32'd1);
        step();
        c_rr = 3'd3; c_req = 5'b01001;
        #1;
        chk("c_rr3", 32'(c_idx), 32'd3);
        chk("c_data3", c_data_o, 32'hC000_0003);
        step();
        c_rr = 3'd4; c_req = 5'b10011;
        #1;
        chk("c_rr4", 32'(c_idx), 32'd4);
        step();
        c_rr = 3'd0; c_req = 5'b10100;
        #1;
        chk("c_rr0", 32'(c_idx), 32'd2);
        c_req = '0; c_flush = 1'b0;

        // Single master passthrough
        step();
        d_req = 1'b1; d_gnt_i = 1'b1;
        #1;
        chk("d_req_o", 32'(d_req_o), 32'd1);
        chk("d_gnt",   32'(d_gnt_o), 32'd1);
        chk("d_idx",   32'(d_idx),   32'd0);
        chk("d_data",  d_data_o,     32'hD000_0000);
        step();
        d_gnt_i = 1'b0;
        #1;
        chk("d_gnt0", 32'(d_gnt_o), 32'd0);
        chk("d_cnt",  32'(d_cnt),   32'd0);

        // Asynchronous reset mid-run clears pointer and counter at once
        step();
        a_req = 4'b1111; a_gnt_i = 1'b1;
        #1;
        chk("pre_idx0", 32'(a_idx), 32'd0);
        step();
        a_req = 4'b0011; a_gnt_i = 1'b0;
        #1;
        chk("pre_idx1", 32'(a_idx), 32'd1);
        chk("pre_cnt_nz", 32'(a_cnt != 4'd0), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(a_cnt), 32'd0);
        chk("arst_idx", 32'(a_idx), 32'd0);
        #1 rst_n = 1'b1;
        step();
        chk("post_cnt", 32'(a_cnt), 32'd1);
        chk("post_idx", 32'(a_idx), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
